// File: rtl/bin_ratio_prepro_gen_if.sv
// Bundles the control, bin-stream and result signals of bin_ratio_prepro_gen.
// master: the side that starts transfers and supplies bins (front end / bench).
// slave:  the preprocessor itself.
//   trans_start         one-cycle transfer start
//   diag_sel            diagonal d, sampled with an accepted trans_start
//   bin_cnt/bin_valid   unsigned bin count and its qualifier
//   processed_dat       signed saturated log ratio
//   processed_dat_addr  output index k
//   processed_dat_ready one-cycle pulse per output
//   prepro_finish       pulse on the last output
//   busy                transfer in progress
interface bin_ratio_prepro_gen_if #(
  parameter int CNT_W  = 20,
  parameter int DIAG_W = 4,
  parameter int OUT_W  = 8,
  parameter int ADDR_W = 10
);
  logic                    trans_start;
  logic [DIAG_W-1:0]       diag_sel;
  logic [CNT_W-1:0]        bin_cnt;
  logic                    bin_valid;
  logic signed [OUT_W-1:0] processed_dat;
  logic [ADDR_W-1:0]       processed_dat_addr;
  logic                    processed_dat_ready;
  logic                    prepro_finish;
  logic                    busy;

  modport master (
    output trans_start, diag_sel, bin_cnt, bin_valid,
    input  processed_dat, processed_dat_addr, processed_dat_ready, prepro_finish, busy
  );

  modport slave (
    input  trans_start, diag_sel, bin_cnt, bin_valid,
    output processed_dat, processed_dat_addr, processed_dat_ready, prepro_finish, busy
  );
endinterface

// File: rtl/bin_ratio_prepro_gen.sv
// Log-ratio preprocessor: takes NUM_BINS bin counts per spectrum, converts each
// to a fixed-point log2 and emits log(bin[k+d+1]) - log(bin[k]) for every valid
// k, saturated to OUT_W signed bits. The diagonal d is chosen per transfer.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset (aborts any transfer)
//   bus    bin_ratio_prepro_gen_if.slave (stream in, results/status out)
module bin_ratio_prepro_gen #(
  parameter int NUM_BINS = 1024,
  parameter int CNT_W    = 20,
  parameter int FRAC_W   = 3,
  parameter int MAX_DIAG = 15,
  parameter int OUT_W    = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  bin_ratio_prepro_gen_if.slave   bus
);
  localparam int P_W    = $clog2(CNT_W);
  localparam int LOG_W  = P_W + FRAC_W;
  localparam int ADDR_W = $clog2(NUM_BINS);
  localparam int DIAG_W = $clog2(MAX_DIAG + 1);
  localparam int SAT_HI = 2 ** (OUT_W - 1) - 1;
  localparam int SAT_LO = -(2 ** (OUT_W - 1));

  localparam logic [DIAG_W-1:0] MAX_D  = DIAG_W'(MAX_DIAG);
  localparam logic [ADDR_W-1:0] LAST_J = ADDR_W'(NUM_BINS - 1);

  typedef enum logic [1:0] {IDLE, FILL, STREAM, DRAIN} state_e;

  state_e            state_q, state_d;
  logic [DIAG_W-1:0] d_q, d_d;
  logic [ADDR_W-1:0] j_q, j_d;
  logic              drain_q, drain_d;
  logic              accept;   // a bin enters the delay line this cycle
  logic              emit;     // that bin also produces an output

  logic [LOG_W-1:0]  sr_q [MAX_DIAG+1];
  logic [LOG_W-1:0]  log_val;

  logic              s1_valid_q, s1_last_q;
  logic [LOG_W-1:0]  s1_num_q, s1_den_q;
  logic [ADDR_W-1:0] s1_addr_q;

  logic signed [OUT_W-1:0] dat_q, sat_val;
  logic [ADDR_W-1:0]       addr_q;
  logic                    ready_q, finish_q;
  int                      diff_i;

  // Leading-one position p followed by the FRAC_W bits just below it.
  // Shifting {cnt, zeros} right by p lines those bits up at the bottom and
  // zero-pads naturally when p < FRAC_W; 0 and 1 both fall out as 0.
  function automatic logic [LOG_W-1:0] log2_fx(input logic [CNT_W-1:0] cnt);
    logic [P_W-1:0]          p;
    logic [CNT_W+FRAC_W-1:0] ext;
    p = '0;
    for (int i = 1; i < CNT_W; i++) begin
      if (cnt[i]) p = P_W'(i);
    end
    ext = {cnt, {FRAC_W{1'b0}}} >> p;
    return {p, ext[FRAC_W-1:0]};
  endfunction

  always_comb log_val = log2_fx(bus.bin_cnt);

  // NOTE: every signal written here gets a default first so no path leaves it
  // unassigned; otherwise synthesis infers a latch.
  always_comb begin
    state_d = state_q;
    d_d     = d_q;
    j_d     = j_q;
    drain_d = drain_q;
    accept  = 1'b0;
    emit    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.trans_start) begin
          state_d = FILL;
          d_d     = (bus.diag_sel > MAX_D) ? MAX_D : bus.diag_sel;
          j_d     = '0;
        end
      end
      FILL: begin
        if (bus.bin_valid) begin
          accept = 1'b1;
          j_d    = j_q + 1'b1;
          if (j_q == ADDR_W'(d_q)) state_d = STREAM;  // bin d+1 accepted
        end
      end
      STREAM: begin
        if (bus.bin_valid) begin
          accept = 1'b1;
          emit   = 1'b1;
          j_d    = j_q + 1'b1;
          if (j_q == LAST_J) begin
            state_d = DRAIN;
            drain_d = 1'b0;
          end
        end
      end
      DRAIN: begin
        // Two cycles: the last bin still sits in the two pipeline stages.
        drain_d = 1'b1;
        if (drain_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      d_q     <= '0;
      j_q     <= '0;
      drain_q <= 1'b0;
      // NOTE: the delay line is small and an abort must leave no stale logs
      // behind, so it is reset like any other register.
      for (int i = 0; i <= MAX_DIAG; i++) sr_q[i] <= '0;
    end else begin
      state_q <= state_d;
      d_q     <= d_d;
      j_q     <= j_d;
      drain_q <= drain_d;
      if (accept) begin
        sr_q[0] <= log_val;
        for (int i = 1; i <= MAX_DIAG; i++) sr_q[i] <= sr_q[i-1];
      end
    end
  end

  // Stage 1: numerator is the incoming bin, denominator the bin d+1 earlier.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_last_q  <= 1'b0;
      s1_num_q   <= '0;
      s1_den_q   <= '0;
      s1_addr_q  <= '0;
    end else begin
      s1_valid_q <= emit;
      if (emit) begin
        s1_num_q  <= log_val;
        s1_den_q  <= sr_q[d_q];
        s1_addr_q <= j_q - ADDR_W'(d_q) - 1'b1;
        s1_last_q <= (j_q == LAST_J);
      end
    end
  end

  // The difference of two unsigned LOG_W values needs LOG_W+1 signed bits;
  // int holds it exactly, which keeps the clamp independent of OUT_W.
  always_comb begin
    diff_i = int'(s1_num_q) - int'(s1_den_q);
    if (diff_i > SAT_HI)      sat_val = OUT_W'(SAT_HI);
    else if (diff_i < SAT_LO) sat_val = OUT_W'(SAT_LO);
    else                      sat_val = OUT_W'(diff_i);
  end

  // Stage 2: data/addr only move with a valid result, so they hold otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_q  <= 1'b0;
      finish_q <= 1'b0;
      dat_q    <= '0;
      addr_q   <= '0;
    end else begin
      ready_q  <= s1_valid_q;
      finish_q <= s1_valid_q & s1_last_q;
      if (s1_valid_q) begin
        dat_q  <= sat_val;
        addr_q <= s1_addr_q;
      end
    end
  end

  assign bus.processed_dat       = dat_q;
  assign bus.processed_dat_addr  = addr_q;
  assign bus.processed_dat_ready = ready_q;
  assign bus.prepro_finish       = finish_q;
  assign bus.busy                = (state_q != IDLE);
endmodule

// File: tb/tb_bin_ratio_prepro_gen.sv
// Bench for bin_ratio_prepro_gen. Two instances: the default 1024-bin build and
// an 8-bin build with MAX_DIAG=5 (so an out-of-range diag_sel is representable).
// The driver pushes expected results into per-instance queues as each bin is
// issued; a monitor pops and compares whenever a ready pulse appears.
`timescale 1ns/1ps
module tb_bin_ratio_prepro_gen;
  localparam int CNT_W  = 20;
  localparam int FRAC_W = 3;
  localparam int OUT_W  = 8;
  localparam int NB_B = 1024, MD_B = 15, DW_B = 4, AW_B = 10;
  localparam int NB_S = 8,    MD_S = 5,  DW_S = 3, AW_S = 3;

  typedef struct {
    int dat;
    int addr;
    bit fin;
    int cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  int   last_dat = 0;
  exp_t sb_b[$];
  exp_t sb_s[$];
  int   bins_q[$];

  bin_ratio_prepro_gen_if #(.CNT_W(CNT_W), .DIAG_W(DW_B), .OUT_W(OUT_W), .ADDR_W(AW_B)) bus_b ();
  bin_ratio_prepro_gen_if #(.CNT_W(CNT_W), .DIAG_W(DW_S), .OUT_W(OUT_W), .ADDR_W(AW_S)) bus_s ();

  bin_ratio_prepro_gen #(.NUM_BINS(NB_B), .CNT_W(CNT_W), .FRAC_W(FRAC_W), .MAX_DIAG(MD_B), .OUT_W(OUT_W))
    u_big (.clk(clk), .rst_n(rst_n), .bus(bus_b));
  bin_ratio_prepro_gen #(.NUM_BINS(NB_S), .CNT_W(CNT_W), .FRAC_W(FRAC_W), .MAX_DIAG(MD_S), .OUT_W(OUT_W))
    u_small (.clk(clk), .rst_n(rst_n), .bus(bus_s));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference log2: floor(log2(cnt)) integer part, then the next FRAC_W bits
  // taken as floor(cnt * 2^FRAC_W / 2^p) minus the implicit leading one.
  function automatic int ref_log(input int cnt);
    int p = 0;
    if (cnt < 2) return 0;
    while ((cnt >> (p + 1)) != 0) p++;
    return p * (1 << FRAC_W) + ((cnt << FRAC_W) >> p) - (1 << FRAC_W);
  endfunction

  function automatic int ref_sat(input int x);
    if (x > 127) return 127;
    if (x < -128) return -128;
    return x;
  endfunction

  function automatic int rand_cnt();
    case ($urandom_range(0, 3))
      0:       return int'($urandom_range(0, 1));
      1:       return int'($urandom_range(2, 255));
      2:       return int'($urandom_range(0, 20'hFFFFF));
      default: return 1 << $urandom_range(0, CNT_W - 1);
    endcase
  endfunction

  function automatic int get_dat(input bit sm);
    return sm ? int'($signed(bus_s.processed_dat)) : int'($signed(bus_b.processed_dat));
  endfunction
  function automatic int get_addr(input bit sm);
    return sm ? int'(bus_s.processed_dat_addr) : int'(bus_b.processed_dat_addr);
  endfunction
  function automatic bit get_busy(input bit sm);
    return sm ? bus_s.busy : bus_b.busy;
  endfunction

  task automatic drv(input bit sm, input bit ts, input int ds, input int cnt, input bit vld);
    if (sm) begin
      bus_s.trans_start = ts;
      bus_s.diag_sel    = DW_S'(ds);
      bus_s.bin_cnt     = CNT_W'(cnt);
      bus_s.bin_valid   = vld;
    end else begin
      bus_b.trans_start = ts;
      bus_b.diag_sel    = DW_B'(ds);
      bus_b.bin_cnt     = CNT_W'(cnt);
      bus_b.bin_valid   = vld;
    end
  endtask

  task automatic check_zero(input bit sm, input string tag);
    check({tag, "_ready"},  sm ? bus_s.processed_dat_ready : bus_b.processed_dat_ready, 0);
    check({tag, "_finish"}, sm ? bus_s.prepro_finish : bus_b.prepro_finish, 0);
    check({tag, "_busy"},   get_busy(sm), 0);
    check({tag, "_dat"},    get_dat(sm), 0);
    check({tag, "_addr"},   get_addr(sm), 0);
  endtask

  task automatic fill_rand(input int n);
    bins_q = {};
    for (int i = 0; i < n; i++) bins_q.push_back(rand_cnt());
  endtask

  // One transfer. gap_mode: 0 = valid every cycle, 1 = every other cycle,
  // 2 = random. ts_at >= 0 re-pulses trans_start with diag ts_d on that bin.
  // abort_at >= 0 pulls rst_n low once that many bins have been accepted.
  task automatic run_xfer(input bit sm, input int dsel, input int gap_mode,
                          input int ts_at, input int ts_d, input int abort_at);
    int   n, d, k, c;
    bit   vld;
    exp_t e;
    n = sm ? NB_S : NB_B;
    d = (dsel > (sm ? MD_S : MD_B)) ? (sm ? MD_S : MD_B) : dsel;
    @(negedge clk);
    drv(sm, 1'b1, dsel, 0, 1'b0);
    @(negedge clk);
    drv(sm, 1'b0, 0, 0, 1'b0);
    check("busy_after_start", get_busy(sm), 1);
    k = 0;
    c = 0;
    while (k < n) begin
      if (k == abort_at) begin
        rst_n = 1'b0;
        #1;
        check_zero(sm, "abort");
        if (sm) sb_s.delete(); else sb_b.delete();
        drv(sm, 1'b0, 0, 0, 1'b0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        return;
      end
      case (gap_mode)
        0:       vld = 1'b1;
        1:       vld = (c % 2 == 0);
        default: vld = ($urandom_range(0, 2) != 0);
      endcase
      drv(sm, (k == ts_at) && vld, ts_d, vld ? bins_q[k] : int'($urandom), vld);
      if (vld) begin
        if (k > d) begin
          e.dat  = ref_sat(ref_log(bins_q[k]) - ref_log(bins_q[k-d-1]));
          e.addr = k - d - 1;
          e.fin  = (k == n - 1);
          e.cyc  = cyc + 2;   // accepting edge, then the stage-2 edge
          last_dat = e.dat;
          if (sm) sb_s.push_back(e); else sb_b.push_back(e);
        end
        k++;
      end
      c++;
      @(negedge clk);
    end
    // DRAIN: stray bins are ignored, and so is a start on the DRAIN->IDLE edge.
    drv(sm, 1'b0, 0, rand_cnt(), 1'b1);
    check("busy_drain", get_busy(sm), 1);
    @(negedge clk);
    drv(sm, 1'b1, 0, rand_cnt(), 1'b1);
    check("busy_drain_last", get_busy(sm), 1);
    @(negedge clk);
    drv(sm, 1'b0, 0, 0, 1'b0);
    check("busy_idle", get_busy(sm), 0);
    for (int t = 0; t < 20 && (sm ? sb_s.size() : sb_b.size()) > 0; t++) @(negedge clk);
    check("sb_empty", sm ? sb_s.size() : sb_b.size(), 0);
    check("busy_after_drain", get_busy(sm), 0);
    check("held_addr", get_addr(sm), n - 2 - d);
    check("held_dat", get_dat(sm), last_dat);
  endtask

  task automatic mon(input bit sm, input bit rdy, input bit fin, input int dat, input int addr);
    exp_t  e;
    string tag;
    tag = sm ? "small" : "big";
    if (!rdy) begin
      check({tag, "_finish_no_ready"}, fin, 0);
      return;
    end
    if ((sm ? sb_s.size() : sb_b.size()) == 0) begin
      check({tag, "_unexpected_ready_qsize"}, 0, 1);
      return;
    end
    e = sm ? sb_s.pop_front() : sb_b.pop_front();
    check({tag, "_dat"},    dat,  e.dat);
    check({tag, "_addr"},   addr, e.addr);
    check({tag, "_finish"}, fin,  e.fin);
    check({tag, "_cycle"},  cyc,  e.cyc);
  endtask

  initial forever begin
    @(posedge clk);
    #1;
    if (rst_n) begin
      mon(1'b0, bus_b.processed_dat_ready, bus_b.prepro_finish, get_dat(1'b0), get_addr(1'b0));
      mon(1'b1, bus_s.processed_dat_ready, bus_s.prepro_finish, get_dat(1'b1), get_addr(1'b1));
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    drv(1'b0, 1'b0, 0, 0, 1'b0);
    drv(1'b1, 1'b0, 0, 0, 1'b0);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_zero(1'b0, "reset_big");
    check_zero(1'b1, "reset_small");
    rst_n = 1'b1;
    @(negedge clk);

    // d=0, flat spectrum: 1023 zero outputs.
    bins_q = {};
    for (int i = 0; i < NB_B; i++) bins_q.push_back(16);
    run_xfer(1'b0, 0, 0, -1, 0, -1);

    // 8 bins, d=2: -32, -36, 0, 0, 0.
    bins_q = {16, 24, 0, 0, 0, 0, 0, 0};
    run_xfer(1'b1, 2, 0, -1, 0, -1);

    // Saturation both ways at the start of a random-gap spectrum.
    fill_rand(NB_B);
    bins_q[0] = 0;
    bins_q[1] = 20'hFFFFF;
    bins_q[2] = 0;
    run_xfer(1'b0, 0, 2, -1, 0, -1);

    // Largest diagonal with bin_valid toggling.
    fill_rand(NB_B);
    run_xfer(1'b0, MD_B, 1, -1, 0, -1);

    // Out-of-range diag_sel clamps to MAX_DIAG.
    fill_rand(NB_S);
    run_xfer(1'b1, 6, 0, -1, 0, -1);
    fill_rand(NB_S);
    run_xfer(1'b1, 7, 1, -1, 0, -1);

    // A second start mid-stream with another diagonal is ignored.
    fill_rand(NB_B);
    run_xfer(1'b0, 3, 0, 100, 9, -1);

    // Reset after 4 bins of a d=0 transfer, then a normal transfer.
    bins_q = {3, 100, 7, 5000, 9, 9, 9, 9};
    run_xfer(1'b1, 0, 0, -1, 0, 4);
    fill_rand(NB_S);
    run_xfer(1'b1, 1, 0, -1, 0, -1);

    // Random short transfers.
    repeat (10) begin
      fill_rand(NB_S);
      run_xfer(1'b1, $urandom_range(0, 7), $urandom_range(0, 2),
               $urandom_range(0, 1) ? $urandom_range(0, 7) : -1, $urandom_range(0, 7), -1);
    end

    repeat (5) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/bin_ratio_prepro_gen.md
Name: bin_ratio_prepro_gen

Overview:
- Next-generation log-ratio preprocessor for the bin-ratio ensemble SNN front end. Streams NUM_BINS spectrum bin counts and applies a fixed-point log2 to each.
- Emits the signed difference log(bin[k+d+1]) - log(bin[k]) for every valid k, with d (the diagonal) selected at run time instead of at synthesis.
- Generalises counter width, bin count, log precision and maximum diagonal. Adds input stalls (valid-qualified bins), output saturation and a busy flag.
- Output addresses feed the SNN input-spike memory.

Parameters:
- NUM_BINS, 1024, bins per spectrum.
- CNT_W, 20, bin count width.
- FRAC_W, 3, fractional log bits.
- MAX_DIAG, 15, largest supported diagonal.
- OUT_W, 8, signed output width.
- Derived: LOG_W = clog2(CNT_W)+FRAC_W; ADDR_W = clog2(NUM_BINS); DIAG_W = clog2(MAX_DIAG+1).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- trans_start  in  1  one-cycle start of a spectrum transfer.
- diag_sel  in  DIAG_W  diagonal d; sampled only when trans_start is accepted.
- bin_cnt  in  CNT_W  bin count, unsigned.
- bin_valid  in  1  bin_cnt is valid this cycle.
- processed_dat  out  OUT_W  signed saturated log ratio.
- processed_dat_addr  out  ADDR_W  output index k.
- processed_dat_ready  out  1  processed_dat/addr valid (one-cycle pulse per output).
- prepro_finish  out  1  one-cycle pulse on the last output.
- busy  out  1  transfer in progress.

Behaviour:
- Reset (asynchronous, active-low): every output is 0; state IDLE; all counters and the delay line are 0. Asserting rst_n low mid-transfer aborts the transfer immediately. No further output pulses are produced.
- Log transform (combinational):
  - cnt = 0 or 1 gives 0.
  - Otherwise p = index of the leading one and f = the FRAC_W bits below it, zero-padded if fewer exist. log = p*2^FRAC_W + f, unsigned LOG_W bits.
  - Examples at the defaults: 16 gives 32; 24 gives 36; 0xFFFFF gives 159.
- States:
  - IDLE to FILL on trans_start. Latch d = min(diag_sel, MAX_DIAG); clear bin counter j; busy = 1.
  - FILL: each accepted bin (bin_valid = 1) shifts its log into the delay line and increments j. When the d+1-th bin is accepted (j becomes d+1), go to STREAM.
  - STREAM: each accepted bin j produces an output. When bin NUM_BINS-1 is accepted, go to DRAIN.
  - DRAIN: wait for the pipeline to empty (2 cycles), then go to IDLE; busy = 0 in the cycle IDLE is re-entered.
- Delay line: MAX_DIAG+1 entries; sr[i] holds the log of bin j-1-i and shifts only on an accepted bin. The denominator for bin j is sr[d]; the numerator is the log of bin j.
- Datapath and latency:
  - Stage 1 registers the numerator, denominator and addr = j-d-1.
  - Stage 2 registers the sign-extended LOG_W+1-bit difference, saturated to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
  - processed_dat_ready pulses exactly 2 cycles after the accepting edge of bin j.
  - Gaps in bin_valid produce matching gaps in the output; order is preserved.
- Output count is NUM_BINS-1-d. Addresses run 0..NUM_BINS-2-d, contiguous and increasing.
- prepro_finish is high in the same cycle as the ready pulse for addr NUM_BINS-2-d.
- Ignored inputs:
  - trans_start while busy = 1 is ignored; the latched d is unchanged.
  - bin_valid in IDLE or DRAIN is ignored.
- Held outputs: processed_dat and addr hold their last values when ready is low.
- If trans_start arrives in the same cycle as the DRAIN-to-IDLE transition, it is ignored. Accept trans_start only in IDLE.

Test Plan:
- Reset mid-STREAM (NUM_BINS=8, d=0, assert rst_n low after 4 bins) -> all outputs 0 at once; no ready pulses after reset; a new trans_start works normally.
- d=0, all bins = 16, bin_valid held high -> 1023 ready pulses, data 0, addr 0..1022. finish coincides with addr 1022. First pulse is 2 cycles after bin 1 is accepted.
- NUM_BINS=8, d=2, bins 16,24,0,0,0,0,0,0 -> 5 outputs: addr0 = 0-32 = -32, addr1 = 0-36 = -36, addr2..4 = 0; finish with addr4.
- Saturation, d=0: bins 0 then 0xFFFFF gives +127; bins 0xFFFFF then 0 gives -128.
- bin_valid toggling every other cycle, d=MAX_DIAG -> outputs are spaced 2 cycles apart with correct addresses. Also: diag_sel = MAX_DIAG+1 (when representable) is clamped to MAX_DIAG.
- trans_start pulsed mid-transfer with a different diag_sel -> ignored; the output count and values follow the original d.
